dma_traffic_gen_chk: RTL and testbench
======================================

Name: dma_traffic_gen_chk

Overview:
Parametrised DMA benchmark engine on the user side of dma_inf. It issues multi-command host read and write bursts with a configurable count, length and address stride. It generates a deterministic write pattern and checks every 32-bit lane of read data against the same pattern. It also reports per-direction cycle counts for throughput measurement, which the previous single-command, lane-limited debug logic could not do.

Parameters:
DATA_W, 512, DMA data width in bits; a power of two, at least 64
ADDR_W, 64, host address width
LEN_W, 32, command length width in bytes
MAX_OUT, 8, maximum commands issued ahead of their data completing, per direction (power of two)
CNT_W, 32, width of op, beat, error and cycle counters

Ports:
user_clk  in  1  sole clock
user_rst  in  1  synchronous active-high reset
rd_start / wr_start  in  1  rising edge starts the read or write run
rd_base / wr_base  in  ADDR_W  first command address
rd_stride / wr_stride  in  ADDR_W  address increment per command
rd_len / wr_len  in  LEN_W  bytes per command
rd_ops / wr_ops  in  CNT_W  number of commands in the run
seed  in  32  pattern seed
rd_cmd_valid/ready, wr_cmd_valid/ready  out/in  1  command handshakes
rd_cmd_addr, wr_cmd_addr  out  ADDR_W;  rd_cmd_len, wr_cmd_len  out  LEN_W
rd_data  in  DATA_W;  rd_valid in 1;  rd_last in 1;  rd_ready out 1
wr_data  out  DATA_W;  wr_keep out DATA_W/8;  wr_valid out 1;  wr_last out 1;  wr_ready in 1
rd_busy, wr_busy, rd_done, wr_done  out  1  run status
rd_cycles, wr_cycles  out  CNT_W  cycles from start edge to final beat accepted
err_cnt  out  CNT_W  mismatching read beats
err_beat  out  CNT_W  global beat index of the first mismatch
err_cfg  out  1  run rejected: illegal length or zero ops

Behaviour:
- Reset: every output is 0 except rd_ready and wr_keep. rd_ready is 1 at all times. wr_keep is all-ones at all times. All FSMs go to IDLE. Reset during a run aborts it with no completion flags.
- Two independent per-direction FSMs, IDLE -> RUN -> DONE -> IDLE.
- IDLE -> RUN:
  - Start edge registered (1 cycle latency).
  - Config latched on the edge and held stable for the run; live inputs are ignored mid-run.
  - The direction's counters clear.
  - Length check: if len == 0, len is not a multiple of DATA_W/8, or ops == 0, set err_cfg, go directly to DONE, and issue no commands.
  - A start edge while in RUN or DONE is ignored.
- RUN command issue:
  - cmd_valid is held until ready.
  - Command address = base + i*stride, computed by accumulator (add stride on each handshake), never by multiply; wrap mod 2^ADDR_W.
  - Issue only while outstanding < MAX_OUT. outstanding increments on a command handshake and decrements on the last beat of a command.
  - Simultaneous command handshake and last beat leaves outstanding unchanged.
- Beats per command: B = len >> log2(DATA_W/8).
- Write data:
  - wr_valid is asserted while outstanding > 0 or a command handshake is occurring.
  - Global beat counter g counts from 0 across the whole run.
  - 32-bit lane j = seed + g + j, wrapping mod 2^32.
  - wr_last is asserted on beat B-1 of each command.
- Read check:
  - The same pattern is applied to every accepted beat.
  - Any lane mismatch increments err_cnt (saturating at all-ones).
  - err_beat captures g on the first mismatch only.
  - A beat arriving in IDLE or DONE is consumed, not checked, and sets no flag.
  - rd_last is not trusted: a mismatch between rd_last and local beat B-1 counts as an error beat.
- RUN -> DONE when ops commands have been issued and ops*B beats accepted.
  - *_cycles freezes at this point; it counts every RUN cycle, including stalls.
  - *_done asserts and holds until the next start edge.
- *_busy is 1 exactly in RUN.

Decomposition:
- Package dma_tg_pkg holds:
  - fsm_t enum {IDLE, RUN, DONE};
  - the function pattern_word(seed, g, DATA_W);
  - the constant BEAT_BYTES = DATA_W/8 and its log2.
- Sub-module dma_tg_cmd_issuer, instantiated once per direction, owns:
  - address accumulation;
  - the command counter;
  - the outstanding counter against MAX_OUT.
- Data generation and checking stay in the top module.

Test Plan:
- Write run: wr_base 0x1000, stride 0x400, len 1024, ops 4, seed 0, wr_ready always 1 -> commands at 0x1000/0x1400/0x1800/0x1C00; 64 beats total; wr_last on beats 15/31/47/63; beat 17 lane 3 = 20; wr_done.
- Loopback read of the same data, rd_valid every cycle, MAX_OUT 2, cmd_ready delayed 5 cycles per command -> outstanding never exceeds 2; err_cnt 0; rd_done; rd_cycles equals the measured RUN duration.
- Same read with beat 37 lane 0 corrupted -> err_cnt 1, err_beat 37.
- rd_len 100 (not a multiple of 64) -> err_cfg 1; no command issued; rd_done after 1 cycle.
- Start edge mid-run, then assert user_rst at beat 10 -> the start edge is ignored; after reset all outputs are 0 and the FSM is in IDLE; a fresh run afterwards completes normally.
- Address wrap: base 2^64-0x400, stride 0x400, ops 2 -> second command address 0; data unaffected.

Source files
------------

// File: rtl/dma_tg_pkg.sv
// Shared types and helpers for the DMA traffic generator / checker.
// Contents:
//   fsm_t        - per-direction run state (IDLE, RUN, DONE)
//   BEAT_BYTES   - bytes per beat at the default data width, BEAT_LOG2 its log2
//   MAX_DATA_W   - widest data bus the pattern helper can fill
//   beat_log2    - log2 of bytes per beat for an arbitrary data width
//   pattern_word - deterministic beat pattern: 32-bit lane j = seed + g + j
package dma_tg_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  localparam int unsigned DEF_DATA_W = 512;
  localparam int unsigned BEAT_BYTES = DEF_DATA_W / 8;
  localparam int unsigned BEAT_LOG2  = $clog2(BEAT_BYTES);
  localparam int unsigned MAX_DATA_W = 4096;

  function automatic int unsigned beat_log2(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  // Lanes at or above data_w/32 are left zero so callers can size-cast the
  // result down to their own bus width.
  function automatic logic [MAX_DATA_W-1:0] pattern_word(input logic [31:0] seed,
                                                         input logic [31:0] g,
                                                         input int unsigned data_w);
    logic [MAX_DATA_W-1:0] w;
    w = '0;
    for (int unsigned j = 0; j < MAX_DATA_W / 32; j++) begin
      if (j < data_w / 32) w[j*32 +: 32] = seed + g + 32'(j);
    end
    return w;
  endfunction

endpackage

// File: rtl/dma_tg_cmd_issuer.sv
// Command issuer for one DMA direction.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   load                - start of run: latch base/stride/ops, clear counters
//   base, stride, ops   - run configuration (sampled on load only)
//   run                 - issuing enabled (direction FSM in RUN)
//   cmd_ready           - command handshake from dma_inf
//   beat_done           - last beat of a command accepted
//   cmd_valid, cmd_addr - command request
//   all_issued          - every command of the run has been handshaken
//   outstanding         - commands issued whose data has not completed
module dma_tg_cmd_issuer import dma_tg_pkg::*; #(
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned MAX_OUT = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic [ADDR_W-1:0]        base,
  input  logic [ADDR_W-1:0]        stride,
  input  logic [CNT_W-1:0]         ops,
  input  logic                     run,
  input  logic                     cmd_ready,
  input  logic                     beat_done,
  output logic                     cmd_valid,
  output logic [ADDR_W-1:0]        cmd_addr,
  output logic                     all_issued,
  output logic [$clog2(MAX_OUT):0] outstanding
);

  localparam int unsigned OUT_W = $clog2(MAX_OUT) + 1;

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [CNT_W-1:0]  ops_q;
  logic [CNT_W-1:0]  issued_q;
  logic [OUT_W-1:0]  out_q;
  logic              fire;
  logic              dec;

  assign all_issued  = (issued_q == ops_q);
  // Valid stays up until ready: nothing that gates it can fall while waiting.
  assign cmd_valid   = run && !all_issued && (out_q < OUT_W'(MAX_OUT));
  assign fire        = cmd_valid && cmd_ready;
  assign dec         = beat_done && (out_q != '0);
  assign cmd_addr    = addr_q;
  assign outstanding = out_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      stride_q <= '0;
      ops_q    <= '0;
      issued_q <= '0;
      out_q    <= '0;
    end else if (load) begin
      addr_q   <= base;
      stride_q <= stride;
      ops_q    <= ops;
      issued_q <= '0;
      out_q    <= '0;
    end else begin
      if (fire) begin
        // Accumulated address, wraps naturally at 2^ADDR_W.
        addr_q   <= addr_q + stride_q;
        issued_q <= issued_q + CNT_W'(1);
      end
      if (fire && !dec) begin
        out_q <= out_q + OUT_W'(1);
      end else if (dec && !fire) begin
        out_q <= out_q - OUT_W'(1);
      end
    end
  end

endmodule

// File: rtl/dma_traffic_gen_chk.sv
// DMA benchmark engine: issues read/write command bursts, generates the write
// pattern, checks read data against it and measures per-direction run cycles.
// Ports:
//   user_clk, user_rst              - clock, synchronous active-high reset
//   rd_/wr_start                    - rising edge starts a run
//   rd_/wr_base, _stride, _len, _ops - run configuration, latched on start
//   seed                            - pattern seed, latched on start
//   rd_/wr_cmd_*                    - command channels
//   rd_data/valid/last, rd_ready    - read data (always accepted)
//   wr_data/keep/valid/last, wr_ready - write data
//   rd_/wr_busy, _done, _cycles     - run status and RUN-cycle counts
//   err_cnt, err_beat, err_cfg      - read mismatches, first bad beat, bad config
module dma_traffic_gen_chk import dma_tg_pkg::*; #(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned LEN_W   = 32,
  parameter int unsigned MAX_OUT = 8,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic                rd_start,
  input  logic                wr_start,
  input  logic [ADDR_W-1:0]   rd_base,
  input  logic [ADDR_W-1:0]   wr_base,
  input  logic [ADDR_W-1:0]   rd_stride,
  input  logic [ADDR_W-1:0]   wr_stride,
  input  logic [LEN_W-1:0]    rd_len,
  input  logic [LEN_W-1:0]    wr_len,
  input  logic [CNT_W-1:0]    rd_ops,
  input  logic [CNT_W-1:0]    wr_ops,
  input  logic [31:0]         seed,
  output logic                rd_cmd_valid,
  input  logic                rd_cmd_ready,
  output logic [ADDR_W-1:0]   rd_cmd_addr,
  output logic [LEN_W-1:0]    rd_cmd_len,
  output logic                wr_cmd_valid,
  input  logic                wr_cmd_ready,
  output logic [ADDR_W-1:0]   wr_cmd_addr,
  output logic [LEN_W-1:0]    wr_cmd_len,
  input  logic [DATA_W-1:0]   rd_data,
  input  logic                rd_valid,
  input  logic                rd_last,
  output logic                rd_ready,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_keep,
  output logic                wr_valid,
  output logic                wr_last,
  input  logic                wr_ready,
  output logic                rd_busy,
  output logic                wr_busy,
  output logic                rd_done,
  output logic                wr_done,
  output logic [CNT_W-1:0]    rd_cycles,
  output logic [CNT_W-1:0]    wr_cycles,
  output logic [CNT_W-1:0]    err_cnt,
  output logic [CNT_W-1:0]    err_beat,
  output logic                err_cfg
);

  localparam int unsigned BEAT_SHIFT = beat_log2(DATA_W);
  localparam int unsigned OUT_W      = $clog2(MAX_OUT) + 1;

  // ---------------------------------------------------------------- write side
  fsm_t             wr_state_q, wr_state_d;
  logic             wr_start_q, wr_go, wr_cfg_bad, wr_run;
  logic [LEN_W-1:0] wr_len_q, wr_bpc, wr_beat_q;
  logic [31:0]      wr_seed_q;
  logic [CNT_W-1:0] wr_g_q, wr_cycles_q;
  logic             wr_done_q, wr_cfg_err_q;
  logic             wr_fire, wr_cmd_fire, wr_beat_last, wr_all_issued, wr_fin;
  logic [OUT_W-1:0] wr_out;

  assign wr_go        = wr_start && !wr_start_q && (wr_state_q == IDLE);
  assign wr_cfg_bad   = (wr_len == '0) || (wr_len[BEAT_SHIFT-1:0] != '0) || (wr_ops == '0);
  assign wr_run       = (wr_state_q == RUN);
  assign wr_bpc       = wr_len_q >> BEAT_SHIFT;
  assign wr_beat_last = (wr_beat_q == wr_bpc - LEN_W'(1));
  assign wr_cmd_fire  = wr_cmd_valid && wr_cmd_ready;
  // Data may go out in the same cycle its command is handshaken.
  assign wr_valid     = wr_run && ((wr_out != '0) || wr_cmd_fire);
  assign wr_fire      = wr_valid && wr_ready;
  assign wr_last      = wr_valid && wr_beat_last;
  assign wr_data      = wr_valid ? DATA_W'(pattern_word(wr_seed_q, 32'(wr_g_q), DATA_W)) : '0;
  assign wr_fin       = wr_all_issued && (wr_out == OUT_W'(1)) && wr_fire && wr_beat_last;

  dma_tg_cmd_issuer #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .MAX_OUT(MAX_OUT)
  ) u_wr_issuer (
    .clk        (user_clk),
    .rst        (user_rst),
    .load       (wr_go),
    .base       (wr_base),
    .stride     (wr_stride),
    .ops        (wr_ops),
    .run        (wr_run),
    .cmd_ready  (wr_cmd_ready),
    .beat_done  (wr_fire && wr_beat_last),
    .cmd_valid  (wr_cmd_valid),
    .cmd_addr   (wr_cmd_addr),
    .all_issued (wr_all_issued),
    .outstanding(wr_out)
  );

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      IDLE:    if (wr_go) wr_state_d = wr_cfg_bad ? DONE : RUN;
      RUN:     if (wr_fin) wr_state_d = DONE;
      DONE:    wr_state_d = IDLE;
      default: wr_state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      wr_state_q   <= IDLE;
      wr_start_q   <= 1'b0;
      wr_len_q     <= '0;
      wr_seed_q    <= '0;
      wr_g_q       <= '0;
      wr_beat_q    <= '0;
      wr_cycles_q  <= '0;
      wr_done_q    <= 1'b0;
      wr_cfg_err_q <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      wr_start_q <= wr_start;
      if (wr_go) begin
        wr_len_q     <= wr_len;
        wr_seed_q    <= seed;
        wr_g_q       <= '0;
        wr_beat_q    <= '0;
        wr_cycles_q  <= '0;
        wr_done_q    <= wr_cfg_bad;
        wr_cfg_err_q <= wr_cfg_bad;
      end else begin
        if (wr_run) wr_cycles_q <= wr_cycles_q + CNT_W'(1);
        if (wr_fin) wr_done_q <= 1'b1;
        if (wr_fire) begin
          wr_g_q    <= wr_g_q + CNT_W'(1);
          wr_beat_q <= wr_beat_last ? '0 : wr_beat_q + LEN_W'(1);
        end
      end
    end
  end

  // ----------------------------------------------------------------- read side
  fsm_t             rd_state_q, rd_state_d;
  logic             rd_start_q, rd_go, rd_cfg_bad, rd_run;
  logic [LEN_W-1:0] rd_len_q, rd_bpc, rd_beat_q;
  logic [31:0]      rd_seed_q;
  logic [CNT_W-1:0] rd_g_q, rd_cycles_q, err_cnt_q, err_beat_q;
  logic             rd_done_q, rd_cfg_err_q;
  logic             rd_fire, rd_beat_last, rd_beat_bad, rd_all_issued, rd_fin;
  logic [OUT_W-1:0] rd_out;

  assign rd_go        = rd_start && !rd_start_q && (rd_state_q == IDLE);
  assign rd_cfg_bad   = (rd_len == '0) || (rd_len[BEAT_SHIFT-1:0] != '0) || (rd_ops == '0);
  assign rd_run       = (rd_state_q == RUN);
  assign rd_bpc       = rd_len_q >> BEAT_SHIFT;
  assign rd_beat_last = (rd_beat_q == rd_bpc - LEN_W'(1));
  // Beats outside RUN are swallowed without being checked.
  assign rd_fire      = rd_valid && rd_run;
  // rd_last is checked against the local beat count, never used to frame.
  assign rd_beat_bad  = (MAX_DATA_W'(rd_data) != pattern_word(rd_seed_q, 32'(rd_g_q), DATA_W))
                     || (rd_last != rd_beat_last);
  assign rd_fin       = rd_all_issued && (rd_out == OUT_W'(1)) && rd_fire && rd_beat_last;

  dma_tg_cmd_issuer #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W),
    .MAX_OUT(MAX_OUT)
  ) u_rd_issuer (
    .clk        (user_clk),
    .rst        (user_rst),
    .load       (rd_go),
    .base       (rd_base),
    .stride     (rd_stride),
    .ops        (rd_ops),
    .run        (rd_run),
    .cmd_ready  (rd_cmd_ready),
    .beat_done  (rd_fire && rd_beat_last),
    .cmd_valid  (rd_cmd_valid),
    .cmd_addr   (rd_cmd_addr),
    .all_issued (rd_all_issued),
    .outstanding(rd_out)
  );

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      IDLE:    if (rd_go) rd_state_d = rd_cfg_bad ? DONE : RUN;
      RUN:     if (rd_fin) rd_state_d = DONE;
      DONE:    rd_state_d = IDLE;
      default: rd_state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      rd_state_q   <= IDLE;
      rd_start_q   <= 1'b0;
      rd_len_q     <= '0;
      rd_seed_q    <= '0;
      rd_g_q       <= '0;
      rd_beat_q    <= '0;
      rd_cycles_q  <= '0;
      rd_done_q    <= 1'b0;
      rd_cfg_err_q <= 1'b0;
      err_cnt_q    <= '0;
      err_beat_q   <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      rd_start_q <= rd_start;
      if (rd_go) begin
        rd_len_q     <= rd_len;
        rd_seed_q    <= seed;
        rd_g_q       <= '0;
        rd_beat_q    <= '0;
        rd_cycles_q  <= '0;
        rd_done_q    <= rd_cfg_bad;
        rd_cfg_err_q <= rd_cfg_bad;
        err_cnt_q    <= '0;
        err_beat_q   <= '0;
      end else begin
        if (rd_run) rd_cycles_q <= rd_cycles_q + CNT_W'(1);
        if (rd_fin) rd_done_q <= 1'b1;
        if (rd_fire) begin
          rd_g_q    <= rd_g_q + CNT_W'(1);
          rd_beat_q <= rd_beat_last ? '0 : rd_beat_q + LEN_W'(1);
          if (rd_beat_bad) begin
            if (err_cnt_q == '0) err_beat_q <= rd_g_q;
            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
          end
        end
      end
    end
  end

  // ------------------------------------------------------------------ outputs
  assign rd_ready   = 1'b1;
  assign wr_keep    = '1;
  assign rd_cmd_len = rd_len_q;
  assign wr_cmd_len = wr_len_q;
  assign rd_busy    = rd_run;
  assign wr_busy    = wr_run;
  assign rd_done    = rd_done_q;
  assign wr_done    = wr_done_q;
  assign rd_cycles  = rd_cycles_q;
  assign wr_cycles  = wr_cycles_q;
  assign err_cnt    = err_cnt_q;
  assign err_beat   = err_beat_q;
  assign err_cfg    = rd_cfg_err_q || wr_cfg_err_q;

endmodule

// File: tb/tb_dma_traffic_gen_chk.sv
module tb_dma_traffic_gen_chk;

  logic         user_clk = 1'b0;
  logic         user_rst = 1'b1;
  logic         rd_start = 1'b0, wr_start = 1'b0;
  logic [63:0]  rd_base = '0, wr_base = '0, rd_stride = '0, wr_stride = '0;
  logic [31:0]  rd_len = '0, wr_len = '0, rd_ops = '0, wr_ops = '0;
  logic [31:0]  seed = '0;
  logic         rd_cmd_valid, rd_cmd_ready = 1'b0, wr_cmd_valid, wr_cmd_ready = 1'b0;
  logic [63:0]  rd_cmd_addr, wr_cmd_addr;
  logic [31:0]  rd_cmd_len, wr_cmd_len;
  logic [511:0] rd_data = '0;
  logic         rd_valid = 1'b0, rd_last = 1'b0, rd_ready;
  logic [511:0] wr_data;
  logic [63:0]  wr_keep;
  logic         wr_valid, wr_last, wr_ready = 1'b0;
  logic         rd_busy, wr_busy, rd_done, wr_done;
  logic [31:0]  rd_cycles, wr_cycles, err_cnt, err_beat;
  logic         err_cfg;

  int checks = 0;
  int errors = 0;

  // Results recorded by the run tasks.
  logic [63:0] wr_addrs [0:7];
  int          nbeats, nlast, ncmds, busy_cyc, max_out;
  logic [31:0] b17_l3;

  always #5 user_clk = ~user_clk;

  dma_traffic_gen_chk #(
    .DATA_W (512),
    .ADDR_W (64),
    .LEN_W  (32),
    .MAX_OUT(2),
    .CNT_W  (32)
  ) dut (
    .user_clk    (user_clk),
    .user_rst    (user_rst),
    .rd_start    (rd_start),
    .wr_start    (wr_start),
    .rd_base     (rd_base),
    .wr_base     (wr_base),
    .rd_stride   (rd_stride),
    .wr_stride   (wr_stride),
    .rd_len      (rd_len),
    .wr_len      (wr_len),
    .rd_ops      (rd_ops),
    .wr_ops      (wr_ops),
    .seed        (seed),
    .rd_cmd_valid(rd_cmd_valid),
    .rd_cmd_ready(rd_cmd_ready),
    .rd_cmd_addr (rd_cmd_addr),
    .rd_cmd_len  (rd_cmd_len),
    .wr_cmd_valid(wr_cmd_valid),
    .wr_cmd_ready(wr_cmd_ready),
    .wr_cmd_addr (wr_cmd_addr),
    .wr_cmd_len  (wr_cmd_len),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_last     (rd_last),
    .rd_ready    (rd_ready),
    .wr_data     (wr_data),
    .wr_keep     (wr_keep),
    .wr_valid    (wr_valid),
    .wr_last     (wr_last),
    .wr_ready    (wr_ready),
    .rd_busy     (rd_busy),
    .wr_busy     (wr_busy),
    .rd_done     (rd_done),
    .wr_done     (wr_done),
    .rd_cycles   (rd_cycles),
    .wr_cycles   (wr_cycles),
    .err_cnt     (err_cnt),
    .err_beat    (err_beat),
    .err_cfg     (err_cfg)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] tb_pat(input logic [31:0] sd, input int g);
    logic [511:0] w;
    for (int j = 0; j < 16; j++) w[j*32 +: 32] = sd + 32'(g) + 32'(j);
    return w;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_busy"}, wr_busy, 0);
    chk({tag, "_rd_busy"}, rd_busy, 0);
    chk({tag, "_wr_done"}, wr_done, 0);
    chk({tag, "_rd_done"}, rd_done, 0);
    chk({tag, "_wr_valid"}, wr_valid, 0);
    chk({tag, "_wr_last"}, wr_last, 0);
    chk({tag, "_wr_cmd_valid"}, wr_cmd_valid, 0);
    chk({tag, "_rd_cmd_valid"}, rd_cmd_valid, 0);
    chk({tag, "_wr_cmd_addr"}, wr_cmd_addr, 0);
    chk({tag, "_rd_cmd_addr"}, rd_cmd_addr, 0);
    chk({tag, "_wr_cmd_len"}, wr_cmd_len, 0);
    chk({tag, "_wr_data_zero"}, (wr_data == '0), 1);
    chk({tag, "_wr_cycles"}, wr_cycles, 0);
    chk({tag, "_rd_cycles"}, rd_cycles, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_err_beat"}, err_beat, 0);
    chk({tag, "_err_cfg"}, err_cfg, 0);
    chk({tag, "_rd_ready"}, rd_ready, 1);
    chk({tag, "_wr_keep"}, wr_keep, 64'hFFFF_FFFF_FFFF_FFFF);
  endtask

  // Write run with wr_cmd_ready/wr_ready held high. restart_at / rst_at are
  // beat counts at which a second start edge / reset is applied (-1: never).
  task automatic run_wr(input logic [63:0] base, input logic [63:0] stride,
                        input logic [31:0] len, input logic [31:0] ops, input logic [31:0] sd,
                        input int restart_at, input int rst_at);
    int  g, bpc, cyc;
    bit  stop, restarted;
    g = 0; bpc = int'(len) / 64; cyc = 0; stop = 0; restarted = 0;
    nbeats = 0; nlast = 0; ncmds = 0; busy_cyc = 0;
    wr_base = base; wr_stride = stride; wr_len = len; wr_ops = ops; seed = sd;
    wr_cmd_ready = 1'b1; wr_ready = 1'b1;
    wr_start = 1'b1;
    @(posedge user_clk); #1;
    wr_start = 1'b0;
    while (!stop) begin
      @(negedge user_clk);
      cyc++;
      if (wr_busy) busy_cyc++;
      if (wr_cmd_valid && wr_cmd_ready) begin
        if (ncmds < 8) wr_addrs[ncmds] = wr_cmd_addr;
        chk("wr_cmd_len", wr_cmd_len, 64'(len));
        ncmds++;
      end
      if (wr_valid && wr_ready) begin
        chk("wr_lane0", wr_data[31:0], 64'(sd + 32'(g)));
        chk("wr_last", wr_last, 64'((g % bpc) == bpc - 1));
        if (wr_last) nlast++;
        if (g == 17) b17_l3 = wr_data[127:96];
        g++;
        nbeats = g;
      end
      if (wr_done || cyc > 3000) stop = 1;
      @(posedge user_clk); #1;
      if (wr_start) begin
        wr_start = 1'b0;
      end else if (g == restart_at && !restarted) begin
        wr_start = 1'b1;
        restarted = 1;
      end
      if (g == rst_at) begin
        user_rst = 1'b1;
        stop = 1;
      end
    end
    if (rst_at < 0) chk("wr_run_completed", wr_done, 1);
  endtask

  // Read run: each command's ready comes after it has been valid for 5 cycles;
  // data for accepted commands streams back one beat per cycle.
  task automatic run_rd(input logic [63:0] base, input logic [63:0] stride,
                        input logic [31:0] len, input logic [31:0] ops, input logic [31:0] sd,
                        input int corrupt_g);
    int g, bpc, cyc, pending, wait_c, outst, loc;
    bit stop;
    g = 0; bpc = int'(len) / 64; cyc = 0; pending = 0; wait_c = 0; outst = 0; loc = 0;
    stop = 0; ncmds = 0; busy_cyc = 0; max_out = 0;
    rd_base = base; rd_stride = stride; rd_len = len; rd_ops = ops; seed = sd;
    rd_start = 1'b1;
    @(posedge user_clk); #1;
    rd_start = 1'b0;
    while (!stop) begin
      rd_cmd_ready = (wait_c >= 5);
      rd_valid = (pending > 0);
      rd_data = '0;
      rd_last = 1'b0;
      if (rd_valid) begin
        rd_data = tb_pat(sd, g);
        if (g == corrupt_g) rd_data[31:0] = rd_data[31:0] ^ 32'h0000_0100;
        rd_last = (loc == bpc - 1);
      end
      @(negedge user_clk);
      cyc++;
      if (rd_busy) busy_cyc++;
      if (rd_cmd_valid && rd_cmd_ready) begin
        chk("rd_cmd_addr", rd_cmd_addr, base + 64'(ncmds) * stride);
        ncmds++;
        pending += bpc;
        outst++;
        wait_c = 0;
      end else if (rd_cmd_valid) begin
        wait_c++;
      end
      if (rd_valid) begin
        pending--;
        g++;
        if (loc == bpc - 1) begin
          loc = 0;
          outst--;
        end else begin
          loc++;
        end
      end
      if (outst > max_out) max_out = outst;
      if (rd_done || cyc > 3000) stop = 1;
      @(posedge user_clk); #1;
    end
    rd_valid = 1'b0;
    rd_last = 1'b0;
    rd_cmd_ready = 1'b0;
    nbeats = g;
    chk("rd_run_completed", rd_done, 1);
  endtask

  initial begin
    // Reset state.
    repeat (3) @(posedge user_clk);
    #1 user_rst = 1'b0;
    @(negedge user_clk);
    check_reset_outputs("reset");

    // Write run: 4 x 1024 B from 0x1000, stride 0x400, seed 0.
    @(posedge user_clk); #1;
    run_wr(64'h1000, 64'h400, 32'd1024, 32'd4, 32'd0, -1, -1);
    chk("wr_ncmds", ncmds, 4);
    chk("wr_addr0", wr_addrs[0], 64'h1000);
    chk("wr_addr1", wr_addrs[1], 64'h1400);
    chk("wr_addr2", wr_addrs[2], 64'h1800);
    chk("wr_addr3", wr_addrs[3], 64'h1C00);
    chk("wr_nbeats", nbeats, 64);
    chk("wr_nlast", nlast, 4);
    chk("wr_b17_lane3", b17_l3, 20);
    chk("wr_cycles", wr_cycles, 64);
    chk("wr_busy_cycles", busy_cyc, 64);
    @(negedge user_clk);
    chk("wr_done_held", wr_done, 1);
    chk("wr_busy_after", wr_busy, 0);

    // Loopback read of the same data, slow command ready, MAX_OUT = 2.
    @(posedge user_clk); #1;
    run_rd(64'h1000, 64'h400, 32'd1024, 32'd4, 32'd0, -1);
    chk("rd_ncmds", ncmds, 4);
    chk("rd_nbeats", nbeats, 64);
    chk("rd_max_outstanding", max_out, 2);
    chk("rd_err_cnt_clean", err_cnt, 0);
    chk("rd_cycles_vs_busy", rd_cycles, 64'(busy_cyc));

    // Same read, beat 37 lane 0 corrupted.
    @(posedge user_clk); #1;
    run_rd(64'h1000, 64'h400, 32'd1024, 32'd4, 32'd0, 37);
    chk("rd_err_cnt_one", err_cnt, 1);
    chk("rd_err_beat", err_beat, 37);

    // Illegal read length.
    @(posedge user_clk); #1;
    rd_len = 32'd100; rd_ops = 32'd4;
    rd_start = 1'b1;
    @(posedge user_clk); #1;
    rd_start = 1'b0;
    @(negedge user_clk);
    chk("badlen_rd_done", rd_done, 1);
    chk("badlen_err_cfg", err_cfg, 1);
    chk("badlen_rd_busy", rd_busy, 0);
    chk("badlen_cmd_valid", rd_cmd_valid, 0);
    repeat (4) @(negedge user_clk);
    chk("badlen_cmd_valid_later", rd_cmd_valid, 0);

    // Zero ops on the write side.
    @(posedge user_clk); #1;
    wr_len = 32'd1024; wr_ops = 32'd0;
    wr_start = 1'b1;
    @(posedge user_clk); #1;
    wr_start = 1'b0;
    @(negedge user_clk);
    chk("zero_ops_wr_done", wr_done, 1);
    chk("zero_ops_wr_cmd_valid", wr_cmd_valid, 0);

    // Start edge mid-run at beat 5 (ignored), reset at beat 10.
    @(posedge user_clk); #1;
    run_wr(64'h1000, 64'h400, 32'd1024, 32'd4, 32'd0, 5, 10);
    chk("midrun_beats_before_reset", nbeats, 10);
    repeat (2) @(posedge user_clk);
    #1 user_rst = 1'b0;
    @(negedge user_clk);
    check_reset_outputs("after_abort");

    // Fresh run after the abort.
    @(posedge user_clk); #1;
    run_wr(64'h1000, 64'h400, 32'd1024, 32'd4, 32'd0, -1, -1);
    chk("fresh_nbeats", nbeats, 64);
    chk("fresh_wr_cycles", wr_cycles, 64);

    // Address wrap at 2^64, seed 5.
    @(posedge user_clk); #1;
    run_wr(64'hFFFF_FFFF_FFFF_FC00, 64'h400, 32'd1024, 32'd2, 32'd5, -1, -1);
    chk("wrap_addr0", wr_addrs[0], 64'hFFFF_FFFF_FFFF_FC00);
    chk("wrap_addr1", wr_addrs[1], 64'h0);
    chk("wrap_nbeats", nbeats, 32);
    chk("wrap_b17_lane3", b17_l3, 25);
    chk("wrap_wr_cycles", wr_cycles, 32);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
